// File: rtl/demux_1x8_reg_n_pkg.sv
// rtl/demux_1x8_reg_n_pkg.sv - shared FSM states, bank geometry and slot helpers
package demux_1x8_reg_n_pkg;

  localparam int SLOTS = 8;
  localparam int BITS_DEF = 7;

  typedef enum logic [1:0] {
    VAZIO   = 2'd0,
    PARCIAL = 2'd1,
    CHEIO   = 2'd2
  } state_t;

  function automatic logic [SLOTS-1:0] slot_mask(input logic [2:0] idx);
    logic [SLOTS-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/demux_1x8_reg_n_if.sv
// rtl/demux_1x8_reg_n_if.sv - write port and bank status bundle
import demux_1x8_reg_n_pkg::*;

interface demux_1x8_reg_n_if #(parameter int BITS = BITS_DEF);
  logic                       clear;
  logic                       we;
  logic                       auto_mode;
  logic [2:0]                 sel;
  logic [BITS-1:0]            d;
  logic [SLOTS-1:0][BITS-1:0] q;
  logic [SLOTS-1:0]           valid;
  logic [2:0]                 ptr;
  logic                       full;
  logic                       done;
  logic                       overrun;
  state_t                     state;

  modport master (
    output clear, we, auto_mode, sel, d,
    input  q, valid, ptr, full, done, overrun, state
  );

  modport slave (
    input  clear, we, auto_mode, sel, d,
    output q, valid, ptr, full, done, overrun, state
  );
endinterface

// File: rtl/demux_1x8_reg_n_contador_m3.sv
// rtl/demux_1x8_reg_n_contador_m3.sv - mod-8 counter with sync clear and enable
module contador_m3 (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  output logic [2:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 3'd0;
    end else if (clear) begin
      count <= 3'd0;
    end else if (en) begin
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/demux_1x8_reg_n.sv
// rtl/demux_1x8_reg_n.sv - registered 1-to-8 write distributor with fill tracking
import demux_1x8_reg_n_pkg::*;

module demux_1x8_reg_n #(
  parameter int BITS = BITS_DEF
) (
  input  logic              clock,
  input  logic              reset,
  demux_1x8_reg_n_if.slave  bus
);

  logic [SLOTS-1:0][BITS-1:0] q_r;
  logic [SLOTS-1:0]           valid_r;
  logic [2:0]                 ptr;
  state_t                     state;
  logic                       done_r;
  logic                       overrun_r;

  logic             rejected;
  logic             accept;
  logic [2:0]       target;
  logic [SLOTS-1:0] next_valid;

  // Only pointer-driven writes bounce off a full bank; explicit writes overwrite.
  assign rejected   = bus.we && !bus.clear && (state == CHEIO) && bus.auto_mode;
  assign accept     = bus.we && !bus.clear && !rejected;
  assign target     = bus.auto_mode ? ptr : bus.sel;
  assign next_valid = valid_r | slot_mask(target);

  contador_m3 u_ptr (
    .clock (clock),
    .reset (reset),
    .clear (bus.clear),
    .en    (accept && bus.auto_mode),
    .count (ptr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_r       <= {SLOTS{{BITS{1'b1}}}};
      valid_r   <= '0;
      state     <= VAZIO;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
      if (bus.clear) begin
        q_r     <= {SLOTS{{BITS{1'b1}}}};
        valid_r <= '0;
        state   <= VAZIO;
      end else if (rejected) begin
        overrun_r <= 1'b1;
      end else if (accept) begin
        q_r[target] <= bus.d;
        valid_r     <= next_valid;
        if (state != CHEIO && next_valid == {SLOTS{1'b1}}) begin
          state  <= CHEIO;
          done_r <= 1'b1;
        end else if (state == VAZIO) begin
          state <= PARCIAL;
        end
      end
    end
  end

  assign bus.q       = q_r;
  assign bus.valid   = valid_r;
  assign bus.ptr     = ptr;
  assign bus.full    = (state == CHEIO);
  assign bus.done    = done_r;
  assign bus.overrun = overrun_r;
  assign bus.state   = state;

endmodule
